// File: rtl/uart_tx_mmio_pkg.sv
// Shared core package: MMIO address map constants and the UART TX FSM state encoding.
// The data-memory stage uses UART_TX_ADDR to decode the TX strobe:
//   wr_en = mem_write && (alu_result == UART_TX_ADDR), wr_data = rs2_data[7:0].
package uart_tx_mmio_pkg;

    localparam logic [31:0] DMEM_BASE    = 32'h1000_0000;
    localparam logic [31:0] UART_TX_ADDR = 32'h2000_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO with power-of-two depth.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (pointers and count cleared)
//   push, wr_data   write request; ignored while full
//   pop, rd_data    read request; ignored while empty; rd_data shows the head entry
//   full, empty     occupancy flags derived from count
//   count           number of stored entries, one bit wider than the pointers
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter (8N1, LSB first) fed by a byte FIFO.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   wr_en      MMIO write strobe for UART_TX_ADDR
//   wr_data    byte to transmit
//   full       FIFO holds FIFO_DEPTH bytes
//   tx_busy    frame in flight or FIFO non-empty
//   overflow   sticky: a write was dropped because the FIFO was full
//   txd        registered serial output, idles high
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       tx_busy,
    output logic       overflow,
    output logic       txd
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

    tx_state_e                   state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [2:0]                  idx_q, idx_d;
    logic [7:0]                  shreg_q, shreg_d;
    logic                        txd_q, txd_d;
    logic                        overflow_q;

    logic                        fifo_pop;
    logic                        fifo_empty;
    logic [7:0]                  fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        bit_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rdata),
        .full    (full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_done = (cnt_q == LAST_TICK);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    txd_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    txd_d   = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        txd_d   = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    cnt_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                        txd_d    = 1'b0;
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
            // full is the registered occupancy, so a same-edge pop cannot rescue the write.
            overflow_q <= overflow_q | (wr_en & full);
        end
    end

    assign txd      = txd_q;
    assign overflow = overflow_q;
    assign tx_busy  = (state_q != StIdle) || (fifo_count != '0);

endmodule
